// File: rtl/keypad_key_detector.sv
// Keypad key detector: re-aligns synchronized rows with their scan column, resolves one key
// per 4-column frame and debounces press/release over whole frames.
module keypad_key_detector #(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int RELEASE_SCANS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_shift_reg,
  input  logic [1:0] column_index,
  input  logic [3:0] row_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0] REL_TARGET = 4'(RELEASE_SCANS);

  // Synchronizer and column alignment pipeline
  logic [3:0] row_s1_q, row_s1_d;
  logic [3:0] row_s_q, row_s_d;
  logic [1:0] col_d1_q, col_d1_d;
  logic [1:0] col_d2_q, col_d2_d;
  logic [3:0] onehot_d1_q, onehot_d1_d;
  logic [3:0] onehot_d2_q, onehot_d2_d;

  // Frame accumulator
  logic       acc_hit_q, acc_hit_d;
  logic       acc_ambig_q, acc_ambig_d;
  logic [3:0] acc_code_q, acc_code_d;

  // FSM and counters
  state_t     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rcnt_q, rcnt_d;

  // Registered outputs
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_pressed_q, key_pressed_d;

  logic       sample_corrupt;
  logic [2:0] n_hits;
  logic [1:0] sample_row;
  logic [3:0] sample_code;
  logic       frame_close;
  logic       frame_hit;
  logic       frame_ambig;
  logic [3:0] frame_code;
  logic       res_single;
  logic [3:0] cnt_inc;
  logic [3:0] rcnt_inc;
  logic       accept;
  logic       release_key;

  always_comb begin
    row_s1_d    = row_in;
    row_s_d     = row_s1_q;
    col_d1_d    = column_index;
    col_d2_d    = col_d1_q;
    onehot_d1_d = col_shift_reg;
    onehot_d2_d = onehot_d1_q;
  end

  // A shift of 1 by the index is always one-hot, so equality also covers the one-hot test
  assign sample_corrupt = (onehot_d2_q != (4'b0001 << col_d2_q));

  assign n_hits = {2'b00, row_s_q[0]} + {2'b00, row_s_q[1]}
                + {2'b00, row_s_q[2]} + {2'b00, row_s_q[3]};

  always_comb begin
    sample_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_s_q[r]) sample_row = 2'(r);
    end
  end

  assign sample_code = {sample_row, col_d2_q};
  assign frame_close = (col_d2_q == 2'd3);

  always_comb begin
    frame_hit   = acc_hit_q | (n_hits != 3'd0);
    frame_ambig = acc_ambig_q | sample_corrupt | (n_hits > 3'd1)
                | (acc_hit_q & (n_hits != 3'd0));
    frame_code  = acc_hit_q ? acc_code_q : sample_code;
  end

  // The closing sample is folded in, and the accumulator restarts on the same edge
  always_comb begin
    acc_hit_d   = frame_hit;
    acc_ambig_d = frame_ambig;
    acc_code_d  = frame_code;
    if (frame_close) begin
      acc_hit_d   = 1'b0;
      acc_ambig_d = 1'b0;
      acc_code_d  = 4'd0;
    end
  end

  assign res_single = frame_close & frame_hit & ~frame_ambig;
  assign cnt_inc    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign rcnt_inc   = (rcnt_q == 4'hF) ? rcnt_q : rcnt_q + 4'd1;

  // Next-state process
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    accept      = 1'b0;
    release_key = 1'b0;
    if (frame_close) begin
      case (state_q)
        ST_IDLE: begin
          if (res_single) begin
            cand_d = frame_code;
            cnt_d  = 4'd1;
            if (DEB_TARGET <= 4'd1) begin
              accept  = 1'b1;
              state_d = ST_PRESSED;
              rcnt_d  = 4'd0;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (res_single) begin
            if (frame_code == cand_q) begin
              cnt_d = cnt_inc;
              if (cnt_inc >= DEB_TARGET) begin
                accept  = 1'b1;
                state_d = ST_PRESSED;
                rcnt_d  = 4'd0;
              end
            end else begin
              cand_d = frame_code;
              cnt_d  = 4'd1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
        ST_PRESSED: begin
          if (res_single && (frame_code == key_code_q)) begin
            rcnt_d = 4'd0;
          end else begin
            rcnt_d = rcnt_inc;
            if (rcnt_inc >= REL_TARGET) begin
              release_key = 1'b1;
              state_d     = ST_IDLE;
              rcnt_d      = 4'd0;
              cnt_d       = 4'd0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          rcnt_d  = 4'd0;
        end
      endcase
    end
  end

  // Output process: key_code is kept after release, key_valid lasts one cycle
  always_comb begin
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_pressed_d = key_pressed_q;
    if (accept) begin
      key_code_d    = cand_d;
      key_valid_d   = 1'b1;
      key_pressed_d = 1'b1;
    end else if (release_key) begin
      key_pressed_d = 1'b0;
    end
  end

  // State register process
  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q      <= 4'd0;
      row_s_q       <= 4'd0;
      col_d1_q      <= 2'd0;
      col_d2_q      <= 2'd0;
      onehot_d1_q   <= 4'd0;
      onehot_d2_q   <= 4'd0;
      acc_hit_q     <= 1'b0;
      acc_ambig_q   <= 1'b0;
      acc_code_q    <= 4'd0;
      state_q       <= ST_IDLE;
      cand_q        <= 4'd0;
      cnt_q         <= 4'd0;
      rcnt_q        <= 4'd0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      row_s1_q      <= row_s1_d;
      row_s_q       <= row_s_d;
      col_d1_q      <= col_d1_d;
      col_d2_q      <= col_d2_d;
      onehot_d1_q   <= onehot_d1_d;
      onehot_d2_q   <= onehot_d2_d;
      acc_hit_q     <= acc_hit_d;
      acc_ambig_q   <= acc_ambig_d;
      acc_code_q    <= acc_code_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      rcnt_q        <= rcnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_key_detector.sv
// Bench for keypad_key_detector: scripted keypad scenarios plus random segments, checked
// against a frame-level reference model through per-cycle and per-key expected queues.
module tb_keypad_key_detector;

  localparam int DEB = 4;
  localparam int REL = 4;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_shift_reg = 4'd0;
  logic [1:0] column_index = 2'd0;
  logic [3:0] row_in = 4'd0;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  always #5 clk = ~clk;

  keypad_key_detector #(
    .DEBOUNCE_SCANS(DEB),
    .RELEASE_SCANS (REL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .col_shift_reg(col_shift_reg),
    .column_index (column_index),
    .row_in       (row_in),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_pressed  (key_pressed)
  );

  // Scoreboard queues: per-cycle {valid, pressed, code} and accepted key codes
  logic [5:0] exp_lvl_q[$];
  logic [3:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  typedef struct {
    logic [3:0] row;
    logic [1:0] col;
    logic [3:0] onehot;
  } smp_t;
  smp_t pipe_q[$];
  int   m_hits[$];
  bit   m_corrupt;
  bit   m_pressed;
  bit   m_valid;
  int   m_code;
  int   m_cand;
  int   m_run;
  int   m_miss;
  logic [1:0] scan_col = 2'd0;

  task automatic model_reset();
    smp_t z;
    z.row = 4'd0; z.col = 2'd0; z.onehot = 4'd0;
    pipe_q.delete();
    pipe_q.push_back(z);
    pipe_q.push_back(z);
    m_hits.delete();
    m_corrupt = 0;
    m_pressed = 0;
    m_valid   = 0;
    m_code    = 0;
    m_cand    = 0;
    m_run     = 0;
    m_miss    = 0;
  endtask

  // One clock edge of the keypad as seen through two cycles of delay
  task automatic model_step(input logic r, input logic [3:0] rows, input logic [1:0] col,
                            input logic [3:0] oh);
    smp_t s, cur;
    bit single;
    int code;
    if (r) begin
      model_reset();
      return;
    end
    s = pipe_q.pop_front();
    cur.row = rows; cur.col = col; cur.onehot = oh;
    pipe_q.push_back(cur);
    m_valid = 0;
    if ($countones(s.onehot) != 1 || s.onehot != (4'b0001 << s.col)) m_corrupt = 1;
    for (int i = 0; i < 4; i++) if (s.row[i]) m_hits.push_back(i * 4 + int'(s.col));
    if (s.col == 2'd3) begin
      single = !m_corrupt && (m_hits.size() == 1);
      code   = single ? m_hits[0] : -1;
      if (!m_pressed) begin
        if (single) begin
          if (m_run > 0 && code == m_cand) m_run++;
          else begin m_cand = code; m_run = 1; end
          if (m_run >= DEB) begin
            m_code = m_cand; m_valid = 1; m_pressed = 1; m_miss = 0; m_run = 0;
            exp_q.push_back(4'(m_code));
          end
        end else m_run = 0;
      end else begin
        if (single && code == m_code) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss >= REL) begin m_pressed = 0; m_run = 0; m_miss = 0; end
        end
      end
      m_hits.delete();
      m_corrupt = 0;
    end
  endtask

  // Driver: one cycle of scanner + keypad, held is a 16-bit mask of pressed key codes
  task automatic drive_cycle(input logic r, input logic [15:0] held, input bit use_ovr,
                             input logic [3:0] ovr);
    logic [3:0] rows;
    logic [3:0] oh;
    @(negedge clk);
    for (int i = 0; i < 4; i++) rows[i] = held[i * 4 + int'(scan_col)];
    oh = use_ovr ? ovr : (4'b0001 << scan_col);
    rst           = r;
    column_index  = scan_col;
    col_shift_reg = oh;
    row_in        = rows;
    model_step(r, rows, scan_col, oh);
    exp_lvl_q.push_back({m_valid, m_pressed, 4'(m_code)});
    scan_col = scan_col + 2'd1;
  endtask

  task automatic run_cycles(input int n, input logic [15:0] held);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, held, 1'b0, 4'd0);
  endtask

  // Monitor: compares every cycle and pops an accepted code on each key_valid
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_lvl_q.size() > 0) begin
        e = exp_lvl_q.pop_front();
        n_vec++;
        if (key_valid !== e[5] || key_pressed !== e[4] || key_code !== e[3:0]) begin
          n_bad++;
          $display("FAIL cycle_outputs t=%0t: got valid=%0b pressed=%0b code=%0d, expected valid=%0b pressed=%0b code=%0d",
                   $time, key_valid, key_pressed, key_code, e[5], e[4], e[3:0]);
        end
      end
      if (key_valid === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid t=%0t: got code=%0d, expected no key", $time, key_code);
        end else begin
          e[3:0] = exp_q.pop_front();
          if (key_code !== e[3:0]) begin
            n_bad++;
            $display("FAIL valid_code t=%0t: got code=%0d, expected code=%0d", $time, key_code, e[3:0]);
          end
        end
      end
    end
  end

  initial begin
    int kind, k1, k2, n;
    model_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 16'd0, 1'b0, 4'd0);
    run_cycles(8, 16'd0);

    // Clean press of key 9, then release
    run_cycles(40, 16'h0200);
    run_cycles(24, 16'd0);
    // Bounce: key 9 in alternating frames
    for (int f = 0; f < 12; f++) run_cycles(4, (f % 2 == 0) ? 16'h0200 : 16'd0);
    run_cycles(12, 16'd0);
    // Two keys on column 2
    run_cycles(32, 16'h4004);
    run_cycles(12, 16'd0);
    // Key change 5 -> 14 without a gap
    run_cycles(24, 16'h0020);
    run_cycles(48, 16'h4000);
    run_cycles(24, 16'd0);
    // Reset mid-press with key 0 held
    run_cycles(24, 16'h0001);
    drive_cycle(1'b1, 16'h0001, 1'b0, 4'd0);
    run_cycles(32, 16'h0001);
    run_cycles(24, 16'd0);
    // Corrupt column drive while key 3 held
    run_cycles(10, 16'h0008);
    drive_cycle(1'b0, 16'h0008, 1'b1, 4'b0011);
    run_cycles(30, 16'h0008);
    run_cycles(24, 16'd0);

    // Random segments with misaligned lengths
    for (int seg = 0; seg < 50; seg++) begin
      kind = $urandom_range(0, 9);
      k1   = $urandom_range(0, 15);
      k2   = $urandom_range(0, 15);
      n    = $urandom_range(1, 30);
      case (kind)
        0, 1, 2, 3, 4: run_cycles(n, 16'(1 << k1));
        5, 6:          run_cycles(n, 16'd0);
        7:             run_cycles(n, 16'(1 << k1) | 16'(1 << k2));
        8: begin
          drive_cycle(1'b1, 16'(1 << k1), 1'b0, 4'd0);
          run_cycles(n, 16'(1 << k1));
        end
        default: begin
          drive_cycle(1'b0, 16'(1 << k1), 1'b1, 4'($urandom_range(0, 15)));
          run_cycles(n, 16'(1 << k1));
        end
      endcase
    end
    run_cycles(40, 16'd0);
    @(negedge clk);
    @(negedge clk);

    n_vec++;
    if (exp_q.size() != 0 || exp_lvl_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_expected: got %0d keys and %0d cycles still queued, expected 0 and 0",
               exp_q.size(), exp_lvl_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
